// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss timer: FSM states, field width,
// field limit and count-direction encodings.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int   TW       = 6;
    localparam int   MAX_VAL  = 59;
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: counts 0..TICKS-1 while enabled, holds otherwise,
// and flags the terminal count as a single-cycle tick.
module tick_gen #(
    parameter int TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICKS);
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Tick is gated by en so a paused or overridden cycle never consumes a second.
    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/timer_core.sv
// mm:ss up/down timer with start/pause/load control feeding the bin2bcd stage.
// Optional TIMER_AUTORELOAD_EN: down-count reloads the last preset at 00:00 and keeps running.
module timer_core #(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int MAX_VAL       = timer_pkg::MAX_VAL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic                    dir,
    input  logic [timer_pkg::TW-1:0] preset_min,
    input  logic [timer_pkg::TW-1:0] preset_sec,
    output logic [timer_pkg::TW-1:0] minute,
    output logic [timer_pkg::TW-1:0] secunde,
    output logic                    running,
    output logic                    done
);

    import timer_pkg::*;

    localparam logic [TW-1:0] MAX_F = TW'(MAX_VAL);

    state_t        state, state_nx;
    logic [TW-1:0] min_nx, sec_nx;
    logic          dir_q, dir_nx, done_nx;
    logic          en, clr, tick, at_zero;

    function automatic logic [TW-1:0] clamp_field(input logic [TW-1:0] v);
        return (v > MAX_F) ? MAX_F : v;
    endfunction

    assign at_zero = (minute == '0) && (secunde == '0);
    // A down-count started at 00:00 stops without consuming a prescaler cycle.
    assign en = (state == RUN) && !load && !pause && !((dir_q == DIR_DOWN) && at_zero);

    tick_gen #(.TICKS(TICKS_PER_SEC)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (clr),
        .tick (tick)
    );

`ifdef TIMER_AUTORELOAD_EN
    logic [TW-1:0] shadow_min, shadow_sec;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_min <= '0;
            shadow_sec <= '0;
        end else if (load) begin
            shadow_min <= clamp_field(preset_min);
            shadow_sec <= clamp_field(preset_sec);
        end
    end
`endif

    always_comb begin
        state_nx = state;
        min_nx   = minute;
        sec_nx   = secunde;
        dir_nx   = dir_q;
        done_nx  = 1'b0;
        clr      = 1'b0;
        if (load) begin
            state_nx = IDLE;
            min_nx   = clamp_field(preset_min);
            sec_nx   = clamp_field(preset_sec);
            clr      = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_nx = RUN;
                        dir_nx   = dir;
                        clr      = 1'b1;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        state_nx = RUN;
                        dir_nx   = dir;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nx = PAUSE;
                    end else if ((dir_q == DIR_DOWN) && at_zero) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else if (tick) begin
                        if (dir_q == DIR_UP) begin
                            if ((minute == MAX_F) && (secunde == MAX_F)) begin
                                state_nx = DONE;
                                done_nx  = 1'b1;
                            end else if (secunde == MAX_F) begin
                                sec_nx = '0;
                                min_nx = minute + 1'b1;
                            end else begin
                                sec_nx = secunde + 1'b1;
                            end
                        end else begin
                            if (secunde == '0) begin
                                sec_nx = MAX_F;
                                min_nx = minute - 1'b1;
                            end else begin
                                sec_nx = secunde - 1'b1;
                            end
                            if ((minute == '0) && (secunde == TW'(1))) begin
                                done_nx = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                                min_nx  = shadow_min;
                                sec_nx  = shadow_sec;
`else
                                state_nx = DONE;
`endif
                            end
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            minute  <= '0;
            secunde <= '0;
            dir_q   <= DIR_UP;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            minute  <= min_nx;
            secunde <= sec_nx;
            dir_q   <= dir_nx;
            running <= (state_nx == RUN);
            done    <= done_nx;
        end
    end

endmodule

// File: tb/tb_timer_core.sv
// Directed bench for timer_core with a 4-cycle second.
module tb_timer_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, pause = 1'b0, load = 1'b0, dir = 1'b0;
    logic [5:0] preset_min = 6'd0, preset_sec = 6'd0;
    logic [5:0] minute, secunde;
    logic       running, done;

    int total = 0;
    int bad   = 0;

    timer_core #(.TICKS_PER_SEC(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .load       (load),
        .dir        (dir),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
        .minute     (minute),
        .secunde    (secunde),
        .running    (running),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish want finish");
        $fatal(1, "bench timeout");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [5:0] m, input logic [5:0] s);
        preset_min = m; preset_sec = s; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic do_start(input logic d);
        dir = d; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        total++; if (minute !== 6'd0) begin bad++; $display("FAIL rst_min: got %0d want 0", minute); end
        total++; if (secunde !== 6'd0) begin bad++; $display("FAIL rst_sec: got %0d want 0", secunde); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL rst_running: got %b want 0", running); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        pause = 1'b1; step(); pause = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL idle_pause_ignored: got %b want 0", running); end
    endtask

    task automatic test_count_up();
        do_start(1'b0);
        dir = 1'b1;
        total++; if (running !== 1'b1) begin bad++; $display("FAIL up_running: got %b want 1", running); end
        step(3);
        total++; if (secunde !== 6'd0) begin bad++; $display("FAIL up_sec_early: got %0d want 0", secunde); end
        step();
        total++; if (secunde !== 6'd1) begin bad++; $display("FAIL up_sec1: got %0d want 1", secunde); end
        step(4);
        total++; if (secunde !== 6'd2) begin bad++; $display("FAIL up_sec2: got %0d want 2", secunde); end
        total++; if (minute !== 6'd0) begin bad++; $display("FAIL up_min: got %0d want 0", minute); end
    endtask

    task automatic test_carry();
        do_load(6'd0, 6'd58);
        total++; if (secunde !== 6'd58) begin bad++; $display("FAIL carry_load_sec: got %0d want 58", secunde); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL carry_load_idle: got %b want 0", running); end
        do_start(1'b0);
        step(4);
        total++; if ({minute, secunde} !== {6'd0, 6'd59}) begin bad++; $display("FAIL carry_0059: got %0d:%0d want 0:59", minute, secunde); end
        step(4);
        total++; if ({minute, secunde} !== {6'd1, 6'd0}) begin bad++; $display("FAIL carry_0100: got %0d:%0d want 1:0", minute, secunde); end
    endtask

`ifndef TIMER_AUTORELOAD_EN
    task automatic test_count_down();
        do_load(6'd0, 6'd2);
        do_start(1'b1);
        step(4);
        total++; if (secunde !== 6'd1) begin bad++; $display("FAIL down_sec1: got %0d want 1", secunde); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL down_done_early: got %b want 0", done); end
        step(4);
        total++; if ({minute, secunde} !== 12'd0) begin bad++; $display("FAIL down_zero: got %0d:%0d want 0:0", minute, secunde); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL down_done: got %b want 1", done); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL down_running: got %b want 0", running); end
        for (int i = 0; i < 20; i++) begin
            step();
            total++;
            if ({done, running, minute, secunde} !== 14'd0) begin
                bad++;
                $display("FAIL down_hold[%0d]: got done=%b run=%b %0d:%0d want 0 0 0:0", i, done, running, minute, secunde);
            end
        end
    endtask
`else
    task automatic test_autoreload();
        do_load(6'd0, 6'd1);
        do_start(1'b1);
        for (int k = 0; k < 3; k++) begin
            step(3);
            total++; if (done !== 1'b0) begin bad++; $display("FAIL ar_done_low[%0d]: got %b want 0", k, done); end
            step();
            total++; if (done !== 1'b1) begin bad++; $display("FAIL ar_done[%0d]: got %b want 1", k, done); end
            total++; if ({minute, secunde} !== {6'd0, 6'd1}) begin bad++; $display("FAIL ar_value[%0d]: got %0d:%0d want 0:1", k, minute, secunde); end
            total++; if (running !== 1'b1) begin bad++; $display("FAIL ar_running[%0d]: got %b want 1", k, running); end
        end
    endtask
`endif

    task automatic test_down_from_zero();
        do_load(6'd0, 6'd0);
        do_start(1'b1);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL zstart_running: got %b want 1", running); end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL zstart_done: got %b want 1", done); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL zstart_stopped: got %b want 0", running); end
    endtask

    task automatic test_clamp_and_restart();
        do_load(6'd63, 6'd62);
        total++; if ({minute, secunde} !== {6'd59, 6'd59}) begin bad++; $display("FAIL clamp: got %0d:%0d want 59:59", minute, secunde); end
        do_start(1'b0);
        step(3);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_early: got %b want 0", done); end
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL max_done: got %b want 1", done); end
        total++; if ({minute, secunde} !== {6'd59, 6'd59}) begin bad++; $display("FAIL max_hold: got %0d:%0d want 59:59", minute, secunde); end
        total++; if (running !== 1'b0) begin bad++; $display("FAIL max_running: got %b want 0", running); end
        do_start(1'b0);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL b2b_running: got %b want 1", running); end
        step(4);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done: got %b want 1", done); end
    endtask

    task automatic test_pause_and_priority();
        do_load(6'd0, 6'd0);
        do_start(1'b0);
        step(2);
        pause = 1'b1; step(); pause = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL pause_running: got %b want 0", running); end
        step(10);
        total++; if (secunde !== 6'd0) begin bad++; $display("FAIL pause_hold: got %0d want 0", secunde); end
        do_start(1'b0);
        total++; if (running !== 1'b1) begin bad++; $display("FAIL resume_running: got %b want 1", running); end
        step();
        total++; if (secunde !== 6'd0) begin bad++; $display("FAIL resume_early: got %0d want 0", secunde); end
        step();
        total++; if (secunde !== 6'd1) begin bad++; $display("FAIL resume_tick: got %0d want 1", secunde); end
        preset_min = 6'd0; preset_sec = 6'd5; load = 1'b1; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0;
        total++; if (running !== 1'b0) begin bad++; $display("FAIL load_wins_running: got %b want 0", running); end
        step(6);
        total++; if (secunde !== 6'd5) begin bad++; $display("FAIL load_wins_idle: got %0d want 5", secunde); end
    endtask

    task automatic test_reset_mid_run();
        do_load(6'd0, 6'd0);
        do_start(1'b0);
        step(6);
        rst = 1'b1; step(); rst = 1'b0;
        total++; if ({minute, secunde} !== 12'd0) begin bad++; $display("FAIL midrst_value: got %0d:%0d want 0:0", minute, secunde); end
        total++; if ({running, done} !== 2'b00) begin bad++; $display("FAIL midrst_ctrl: got %b%b want 00", running, done); end
        do_start(1'b0);
        step(3);
        total++; if (secunde !== 6'd0) begin bad++; $display("FAIL midrst_restart_early: got %0d want 0", secunde); end
        step();
        total++; if (secunde !== 6'd1) begin bad++; $display("FAIL midrst_restart_tick: got %0d want 1", secunde); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_carry();
`ifndef TIMER_AUTORELOAD_EN
        test_count_down();
`else
        test_autoreload();
`endif
        test_down_from_zero();
        test_clamp_and_restart();
        test_pause_and_priority();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
